memoria_instrucciones: RTL and testbench

- Word-organised instruction memory (ROM-like) feeding the fetch stage of the single-cycle RV32I datapath.
- Takes the byte address from the PC and returns the 32-bit instruction combinationally.
- Holds a fixed 14-word default program at byte addresses 0..52.
- Has a synchronous program-load port; reset restores the default image.

---
 rtl/memoria_instrucciones_pkg.sv | 43 ++++
 rtl/memoria_instrucciones.sv | 94 +++++++++
 tb/tb_memoria_instrucciones.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/memoria_instrucciones_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared constants for the RV32I instruction memory:
//   NOP_WORD       - canonical RV32I NOP (addi x0,x0,0), used as fill value
//   DEFAULT_LEN    - number of words in the built-in program
//   DEFAULT_IMAGE  - the built-in program, word 0 at byte address 0
//   default_word() - default content of any word index (program or NOP fill)
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
  localparam int unsigned DEFAULT_LEN = 14;

  // Built-in program. The tail word at byte 48 is "jal x0,0" (spin in place),
  // followed by a NOP at byte 52.
  localparam logic [31:0] DEFAULT_IMAGE [DEFAULT_LEN] = '{
    32'h0050_0093,  // 0x00
    32'h00A0_0113,  // 0x04
    32'h0020_81B3,  // 0x08
    32'h4011_0233,  // 0x0C
    32'h0020_F2B3,  // 0x10
    32'h0020_E333,  // 0x14
    32'h0030_2023,  // 0x18
    32'h0000_2383,  // 0x1C
    32'h0071_8463,  // 0x20
    32'h0010_0413,  // 0x24
    32'h0020_A4B3,  // 0x28
    32'h0020_C533,  // 0x2C
    32'h0000_006F,  // 0x30
    32'h0000_0013   // 0x34
  };

  // Default content for word index idx: program word if inside the image,
  // otherwise the supplied fill value.
  function automatic logic [31:0] default_word(input int unsigned idx,
                                               input logic [31:0] fill);
    if (idx < DEFAULT_LEN) begin
      return DEFAULT_IMAGE[idx];
    end
    return fill;
  endfunction

endpackage

// File: rtl/memoria_instrucciones.sv
// -----------------------------------------------------------------------------
// memoria_instrucciones
// Word-organised instruction memory for the single-cycle RV32I fetch stage.
// Combinational read from the PC byte address, synchronous program-load port,
// synchronous reset that restores the built-in program image.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high, reloads the default image
//   address    in   byte address from the PC
//   inst       out  instruction word at address (NOP_WORD when out of range)
//   prog_we    in   program-load write enable
//   prog_addr  in   byte address for the load write (bits [1:0] ignored)
//   prog_data  in   word to write
//   addr_err   out  address is outside 0 .. 4*DEPTH-1
//   misaligned out  address[1:0] != 0
// -----------------------------------------------------------------------------
module memoria_instrucciones
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_FILL = DATA_W'(imem_pkg::NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] inst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              addr_err,
  output logic              misaligned
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  // Lowest byte-address bit above the word index; any set bit from here up
  // means the address lies beyond the stored words.
  localparam int unsigned HI_LSB = IDX_W + 2;

  typedef logic [DATA_W-1:0] mem_t [DEPTH];

  // Full default memory content, used both for power-up and for reset.
  function automatic mem_t default_mem();
    mem_t m;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      m[i] = DATA_W'(default_word(i, 32'(NOP_FILL)));
    end
    return m;
  endfunction

  // Declaration initialiser gives the power-up image, so fetch works before
  // the first reset.
  mem_t mem_q = default_mem();

  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_in_range;
  logic             unused_prog_lsb;

  assign rd_idx      = address[IDX_W+1:2];
  assign rd_in_range = (address[ADDR_W-1:HI_LSB] == '0);
  assign wr_idx      = prog_addr[IDX_W+1:2];
  assign wr_in_range = (prog_addr[ADDR_W-1:HI_LSB] == '0);

  // Byte offset of the load address carries no meaning for word writes.
  assign unused_prog_lsb = ^prog_addr[1:0];

  // Reset beats a simultaneous load; out-of-range loads are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_W'(default_word(i, 32'(NOP_FILL)));
      end
    end else if (prog_we && wr_in_range) begin
      mem_q[wr_idx] <= prog_data;
    end
  end

  // Read path is purely combinational with no write-through: a word written
  // this cycle appears only after the edge.
  always_comb begin
    inst = NOP_FILL;
    if (rd_in_range) begin
      inst = mem_q[rd_idx];
    end
  end

  assign addr_err   = ~rd_in_range;
  assign misaligned = |address[1:0];

endmodule

// File: tb/tb_memoria_instrucciones.sv
module tb_memoria_instrucciones;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] inst;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        addr_err;
  logic        misaligned;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] img [14] = '{
    32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233,
    32'h0020F2B3, 32'h0020E333, 32'h00302023, 32'h00002383,
    32'h00718463, 32'h00100413, 32'h0020A4B3, 32'h0020C533,
    32'h0000006F, 32'h00000013
  };

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_inst;
    logic        exp_err;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [20];

  memoria_instrucciones dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .inst       (inst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .addr_err   (addr_err),
    .misaligned (misaligned)
  );

  always #5 clk = ~clk;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Read at an address without touching the clock edge.
  task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check32(name, inst, exp);
  endtask

  // Advance through one rising edge, leaving time 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input int idx);
    if (idx < 14) return img[idx];
    return NOP;
  endfunction

  initial begin
    reset     = 1'b0;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    address   = '0;

    // Table: default program sweep plus range / alignment corners.
    for (int i = 0; i < 14; i++) begin
      vecs[i] = '{addr: 32'(i * 4), exp_inst: img[i], exp_err: 1'b0, exp_mis: 1'b0};
    end
    vecs[14] = '{addr: 32'd56,        exp_inst: NOP,          exp_err: 1'b0, exp_mis: 1'b0};
    vecs[15] = '{addr: 32'd252,       exp_inst: NOP,          exp_err: 1'b0, exp_mis: 1'b0};
    vecs[16] = '{addr: 32'd256,       exp_inst: NOP,          exp_err: 1'b1, exp_mis: 1'b0};
    vecs[17] = '{addr: 32'hFFFFFFFC,  exp_inst: NOP,          exp_err: 1'b1, exp_mis: 1'b0};
    vecs[18] = '{addr: 32'd9,         exp_inst: 32'h002081B3, exp_err: 1'b0, exp_mis: 1'b1};
    vecs[19] = '{addr: 32'd258,       exp_inst: NOP,          exp_err: 1'b1, exp_mis: 1'b1};

    // Power-up image: no reset applied before these reads.
    #2;
    for (int i = 0; i < 20; i++) begin
      address = vecs[i].addr;
      #5;
      check32($sformatf("inst@%08h", vecs[i].addr), inst, vecs[i].exp_inst);
      check1($sformatf("addr_err@%08h", vecs[i].addr), addr_err, vecs[i].exp_err);
      check1($sformatf("misaligned@%08h", vecs[i].addr), misaligned, vecs[i].exp_mis);
    end

    // Program load at byte 8, with old word visible until the edge.
    @(negedge clk);
    address   = 32'd8;
    prog_we   = 1'b1;
    prog_addr = 32'd8;
    prog_data = 32'hDEADBEEF;
    #1;
    check32("rdw_old_before_edge", inst, 32'h002081B3);
    tick();
    prog_we = 1'b0;
    check32("write_8_new", inst, 32'hDEADBEEF);
    read_chk("write_8_neighbour_4", 32'd4, 32'h00A00113);
    read_chk("write_8_neighbour_12", 32'd12, 32'h40110233);

    // Reset restores the default word.
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_chk("reset_restores_8", 32'd8, 32'h002081B3);

    // Reset has priority over a simultaneous write.
    @(negedge clk);
    reset     = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 32'd0;
    prog_data = 32'h12345678;
    tick();
    reset   = 1'b0;
    prog_we = 1'b0;
    read_chk("reset_beats_write", 32'd0, 32'h00500093);

    // Top word write with byte offset bits set in prog_addr.
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 32'd255;
    prog_data = 32'hCAFEF00D;
    tick();
    prog_we = 1'b0;
    read_chk("write_top_word", 32'd252, 32'hCAFEF00D);
    @(negedge clk);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    read_chk("reset_clears_top", 32'd252, NOP);

    // Out-of-range write must not alias onto any stored word.
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = 32'd400;
    prog_data = 32'hBAD0BAD0;
    tick();
    prog_we = 1'b0;
    read_chk("oor_write_read400", 32'd400, NOP);
    check1("oor_write_err", addr_err, 1'b1);
    for (int i = 0; i < 64; i++) begin
      read_chk($sformatf("readback_%0d", i * 4), 32'(i * 4), model_word(i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
